// File: rtl/alarm_time_source_pkg.sv
// Shared definitions for the alarm time source: FSM encoding, calendar
// limits and small range/day helpers used by the counter and the top.
package alarm_time_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RINGING  = 2'd1,
    ST_SNOOZING = 2'd2
  } state_t;

  localparam int HOURS    = 24;
  localparam int MINS     = 60;
  localparam int SECS     = 60;
  localparam int DAYS     = 7;
  localparam int SUNDAY   = 0;
  localparam int SATURDAY = 6;

  // Monday..Friday
  function automatic logic is_weekday(input logic [2:0] d);
    return (d != 3'(SUNDAY)) && (d != 3'(SATURDAY)) && (d < 3'(DAYS));
  endfunction

  // Hour and minute both inside their calendar range
  function automatic logic hm_valid(input logic [4:0] h, input logic [5:0] m);
    return (h < 5'(HOURS)) && (m < 6'(MINS));
  endfunction

endpackage

// File: rtl/alarm_time_source_tod.sv
// Time-of-day / day-of-week counter chain. Exposes the next-state time and
// a minute-rollover strobe so the alarm compare sees the values that will
// appear on the outputs after this edge.
module tod_counter
  import alarm_time_source_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       time_load,
  input  logic [4:0] load_hour,
  input  logic [5:0] load_min,
  input  logic [2:0] load_day,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [2:0] day,
  output logic       weekday_out,
  output logic       load_ok,
  output logic       min_roll,
  output logic [4:0] hour_next,
  output logic [5:0] minute_next,
  output logic [2:0] day_next
);

  logic [5:0] second_next;
  logic       sec_wrap;
  logic       min_wrap;
  logic       hour_wrap;
  logic       day_wrap;

  // Load acceptance and carry detection
  always_comb begin
    load_ok   = time_load && hm_valid(load_hour, load_min) && (load_day < 3'(DAYS));
    sec_wrap  = (second == 6'(SECS - 1));
    min_wrap  = (minute == 6'(MINS - 1));
    hour_wrap = (hour == 5'(HOURS - 1));
    day_wrap  = (day == 3'(SATURDAY));
    min_roll  = !load_ok && sec_tick && sec_wrap;
  end

  // Next time value: a valid load wins over a coincident tick
  always_comb begin
    second_next = second;
    minute_next = minute;
    hour_next   = hour;
    day_next    = day;
    if (load_ok) begin
      second_next = '0;
      minute_next = load_min;
      hour_next   = load_hour;
      day_next    = load_day;
    end else if (sec_tick) begin
      second_next = sec_wrap ? 6'd0 : second + 6'd1;
      if (sec_wrap) begin
        minute_next = min_wrap ? 6'd0 : minute + 6'd1;
        if (min_wrap) begin
          hour_next = hour_wrap ? 5'd0 : hour + 5'd1;
          if (hour_wrap) begin
            day_next = day_wrap ? 3'd0 : day + 3'd1;
          end
        end
      end
    end
  end

  // Time registers; weekday flag is derived from the next day so it moves with day
  always_ff @(posedge clk) begin
    if (reset) begin
      second      <= '0;
      minute      <= '0;
      hour        <= '0;
      day         <= '0;
      weekday_out <= 1'b0;
    end else begin
      second      <= second_next;
      minute      <= minute_next;
      hour        <= hour_next;
      day         <= day_next;
      weekday_out <= is_weekday(day_next);
    end
  end

endmodule

// File: rtl/alarm_time_source.sv
// Time keeper with a programmable alarm and ring/snooze state machine.
// Feeds alarm_out and weekday_out to the wake-state FSM downstream.
module alarm_time_source
  import alarm_time_source_pkg::*;
#(
  parameter int RING_SECS   = 30,
  parameter int SNOOZE_MINS = 9,
  parameter int MAX_SNOOZES = 3,
  parameter int WEEKEND_EN  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       time_load,
  input  logic [4:0] load_hour,
  input  logic [5:0] load_min,
  input  logic [2:0] load_day,
  input  logic       alarm_load,
  input  logic       alarm_arm,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       alarm_out,
  output logic       weekday_out,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [2:0] day,
  output logic       snoozing
);

  logic       load_ok;
  logic       min_roll;
  logic [4:0] hour_next;
  logic [5:0] minute_next;
  logic [2:0] day_next;

  logic [4:0] alarm_hour_reg;
  logic [5:0] alarm_min_reg;
  state_t     state_reg;
  logic [7:0] ring_timer_reg;
  logic [5:0] snooze_timer_reg;
  logic [7:0] snooze_count_reg;
  logic       match;

  tod_counter u_tod (
    .clk         (clk),
    .reset       (reset),
    .sec_tick    (sec_tick),
    .time_load   (time_load),
    .load_hour   (load_hour),
    .load_min    (load_min),
    .load_day    (load_day),
    .hour        (hour),
    .minute      (minute),
    .second      (second),
    .day         (day),
    .weekday_out (weekday_out),
    .load_ok     (load_ok),
    .min_roll    (min_roll),
    .hour_next   (hour_next),
    .minute_next (minute_next),
    .day_next    (day_next)
  );

  // Alarm fires only on a tick that lands on hh:mm:00; loads never match
  always_comb begin
    match = min_roll && alarm_arm
         && (hour_next == alarm_hour_reg) && (minute_next == alarm_min_reg)
         && (is_weekday(day_next) || (WEEKEND_EN != 0));
  end

  // Alarm time register, out-of-range requests are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_hour_reg <= '0;
      alarm_min_reg  <= '0;
    end else if (alarm_load && hm_valid(load_hour, load_min)) begin
      alarm_hour_reg <= load_hour;
      alarm_min_reg  <= load_min;
    end
  end

  // Ring/snooze FSM; outputs are updated together with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      ring_timer_reg   <= '0;
      snooze_timer_reg <= '0;
      snooze_count_reg <= '0;
      alarm_out        <= 1'b0;
      snoozing         <= 1'b0;
    end else if (load_ok) begin
      state_reg        <= ST_IDLE;
      snooze_count_reg <= '0;
      alarm_out        <= 1'b0;
      snoozing         <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (match) begin
            state_reg        <= ST_RINGING;
            ring_timer_reg   <= '0;
            snooze_count_reg <= '0;
            alarm_out        <= 1'b1;
            snoozing         <= 1'b0;
          end
        end
        ST_RINGING: begin
          if (dismiss) begin
            state_reg <= ST_IDLE;
            alarm_out <= 1'b0;
            snoozing  <= 1'b0;
          end else if (snooze) begin
            if (snooze_count_reg < 8'(MAX_SNOOZES)) begin
              state_reg        <= ST_SNOOZING;
              snooze_count_reg <= snooze_count_reg + 8'd1;
              snooze_timer_reg <= '0;
              alarm_out        <= 1'b0;
              snoozing         <= 1'b1;
            end else begin
              state_reg <= ST_IDLE;
              alarm_out <= 1'b0;
              snoozing  <= 1'b0;
            end
          end else if (sec_tick) begin
            if (ring_timer_reg == 8'(RING_SECS - 1)) begin
              state_reg <= ST_IDLE;
              alarm_out <= 1'b0;
              snoozing  <= 1'b0;
            end else begin
              ring_timer_reg <= ring_timer_reg + 8'd1;
            end
          end
        end
        ST_SNOOZING: begin
          if (dismiss) begin
            state_reg <= ST_IDLE;
            alarm_out <= 1'b0;
            snoozing  <= 1'b0;
          end else if (min_roll) begin
            if (snooze_timer_reg == 6'(SNOOZE_MINS - 1)) begin
              state_reg      <= ST_RINGING;
              ring_timer_reg <= '0;
              alarm_out      <= 1'b1;
              snoozing       <= 1'b0;
            end else begin
              snooze_timer_reg <= snooze_timer_reg + 6'd1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          alarm_out <= 1'b0;
          snoozing  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_time_source.sv
// Bench for alarm_time_source: two instances (weekend alarms off/on) share
// stimulus; a seconds-of-week model predicts every output on every cycle.
module tb_alarm_time_source;

  localparam int RING   = 30;
  localparam int SNZ    = 9;
  localparam int MAXS   = 3;
  localparam int WEEK   = 7 * 86400;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sec_tick = 1'b0;
  logic       time_load = 1'b0;
  logic [4:0] load_hour = '0;
  logic [5:0] load_min = '0;
  logic [2:0] load_day = '0;
  logic       alarm_load = 1'b0;
  logic       alarm_arm = 1'b0;
  logic       snooze = 1'b0;
  logic       dismiss = 1'b0;

  logic       alarm_o   [2];
  logic       weekday_o [2];
  logic [4:0] hour_o    [2];
  logic [5:0] minute_o  [2];
  logic [5:0] second_o  [2];
  logic [2:0] day_o     [2];
  logic       snoozing_o[2];

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Model: time as seconds since Sunday 00:00:00, alarm as minute-of-day,
  // ring/snooze tracked as countdowns.
  int m_t[2], m_alh[2], m_alm[2], m_used[2], m_ring_left[2], m_rolls_left[2];
  bit m_ring[2], m_snz[2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    alarm_time_source #(
      .RING_SECS(RING), .SNOOZE_MINS(SNZ), .MAX_SNOOZES(MAXS), .WEEKEND_EN(gi)
    ) u_dut (
      .clk(clk), .reset(reset), .sec_tick(sec_tick), .time_load(time_load),
      .load_hour(load_hour), .load_min(load_min), .load_day(load_day),
      .alarm_load(alarm_load), .alarm_arm(alarm_arm), .snooze(snooze),
      .dismiss(dismiss), .alarm_out(alarm_o[gi]), .weekday_out(weekday_o[gi]),
      .hour(hour_o[gi]), .minute(minute_o[gi]), .second(second_o[gi]),
      .day(day_o[gi]), .snoozing(snoozing_o[gi])
    );
  end

  task automatic check(input string name, input int k, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int nt, nd;
    bit roll, match, vload;
    vload = time_load && load_hour < 24 && load_min < 60 && load_day < 7;
    if (reset) begin
      m_t[k] = 0; m_alh[k] = 0; m_alm[k] = 0; m_used[k] = 0;
      m_ring[k] = 0; m_snz[k] = 0;
      return;
    end
    nt = m_t[k]; roll = 0; match = 0;
    if (vload) begin
      nt = ((int'(load_day) * 24 + int'(load_hour)) * 60 + int'(load_min)) * 60;
    end else if (sec_tick) begin
      nt = (m_t[k] + 1) % WEEK;
      roll = (nt % 60 == 0);
      nd = nt / 86400;
      match = roll && ((nt / 60) % 1440 == m_alh[k] * 60 + m_alm[k]) && alarm_arm
              && ((nd >= 1 && nd <= 5) || k == 1);
    end
    if (vload) begin
      m_ring[k] = 0; m_snz[k] = 0; m_used[k] = 0;
    end else if (m_ring[k]) begin
      if (dismiss) m_ring[k] = 0;
      else if (snooze) begin
        m_ring[k] = 0;
        if (m_used[k] < MAXS) begin
          m_snz[k] = 1; m_used[k]++; m_rolls_left[k] = SNZ;
        end
      end else if (sec_tick) begin
        m_ring_left[k]--;
        if (m_ring_left[k] == 0) m_ring[k] = 0;
      end
    end else if (m_snz[k]) begin
      if (dismiss) m_snz[k] = 0;
      else if (roll) begin
        m_rolls_left[k]--;
        if (m_rolls_left[k] == 0) begin
          m_snz[k] = 0; m_ring[k] = 1; m_ring_left[k] = RING;
        end
      end
    end else if (match) begin
      m_ring[k] = 1; m_ring_left[k] = RING; m_used[k] = 0;
    end
    if (alarm_load && load_hour < 24 && load_min < 60) begin
      m_alh[k] = int'(load_hour); m_alm[k] = int'(load_min);
    end
    m_t[k] = nt;
  endtask

  // Advance the model on each active edge
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  // Compare every output of both instances against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        int d;
        d = m_t[k] / 86400;
        check("hour",     k, int'(hour_o[k]),     (m_t[k] / 3600) % 24);
        check("minute",   k, int'(minute_o[k]),   (m_t[k] / 60) % 60);
        check("second",   k, int'(second_o[k]),   m_t[k] % 60);
        check("day",      k, int'(day_o[k]),      d);
        check("weekday",  k, int'(weekday_o[k]),  (d >= 1 && d <= 5) ? 1 : 0);
        check("alarm_out",k, int'(alarm_o[k]),    int'(m_ring[k]));
        check("snoozing", k, int'(snoozing_o[k]), int'(m_snz[k]));
      end
    end
  end

  task automatic clr();
    sec_tick = 0; time_load = 0; alarm_load = 0; snooze = 0; dismiss = 0;
  endtask

  task automatic idle_cyc();
    @(negedge clk); clr();
  endtask

  task automatic tick();
    @(negedge clk); clr(); sec_tick = 1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick();
      if ($urandom_range(0, 3) == 0) idle_cyc();
    end
  endtask

  task automatic load_time(input int h, input int m, input int d);
    @(negedge clk); clr();
    time_load = 1; load_hour = 5'(h); load_min = 6'(m); load_day = 3'(d);
  endtask

  task automatic load_both(input int ah, input int am, input int h, input int m, input int d);
    // Alarm and time share the load buses, so both requests carry the same
    // hour/minute here; the time is loaded one minute early on a second cycle.
    @(negedge clk); clr();
    alarm_load = 1; time_load = 1; load_hour = 5'(ah); load_min = 6'(am); load_day = 3'(d);
    load_time(h, m, d);
  endtask

  task automatic do_snooze();
    @(negedge clk); clr(); snooze = 1;
  endtask

  task automatic do_dismiss();
    @(negedge clk); clr(); dismiss = 1;
  endtask

  task automatic lit_alarm(input string name, input int e0, input int e1);
    check(name, 0, int'(alarm_o[0]), e0);
    check(name, 1, int'(alarm_o[1]), e1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 0;
    idle_cyc();
    cmp_en = 1;
    check("rst_hour", 0, int'(hour_o[0]), 0);
    check("rst_day", 0, int'(day_o[0]), 0);
    lit_alarm("rst_alarm", 0, 0);
    check("rst_snoozing", 0, int'(snoozing_o[0]), 0);

    // Week rollover
    load_time(23, 59, 6);
    ticks(60);
    idle_cyc();
    check("wrap_hour", 0, int'(hour_o[0]), 0);
    check("wrap_min", 0, int'(minute_o[0]), 0);
    check("wrap_sec", 0, int'(second_o[0]), 0);
    check("wrap_day", 0, int'(day_o[0]), 0);
    check("wrap_weekday", 0, int'(weekday_o[0]), 0);

    // Weekday alarm and auto-timeout
    alarm_arm = 1;
    load_both(7, 0, 6, 59, 1);
    ticks(59);
    idle_cyc();
    lit_alarm("pre_match", 0, 0);
    tick();
    idle_cyc();
    lit_alarm("match", 1, 1);
    ticks(29);
    idle_cyc();
    lit_alarm("ring_29", 1, 1);
    tick();
    idle_cyc();
    lit_alarm("timeout", 0, 0);

    // Sunday: only the weekend-enabled instance rings
    load_time(6, 59, 0);
    ticks(60);
    idle_cyc();
    lit_alarm("sunday", 0, 1);
    do_dismiss();
    idle_cyc();
    lit_alarm("sun_dismiss", 0, 0);

    // Snooze cycle: ring at 07:00:00, snooze at :05, re-ring after 535 ticks
    load_time(6, 59, 1);
    ticks(60);
    idle_cyc();
    lit_alarm("snz_ring", 1, 1);
    for (int s = 0; s < MAXS; s++) begin
      ticks(5);
      do_snooze();
      idle_cyc();
      check("snz_on", 0, int'(snoozing_o[0]), 1);
      lit_alarm("snz_quiet", 0, 0);
      n = 0;
      while (alarm_o[0] == 1'b0 && n < 700) begin
        tick();
        idle_cyc();
        n++;
      end
      check("snz_ticks", s, n, 535);
    end
    ticks(5);
    do_snooze();
    idle_cyc();
    lit_alarm("snz_limit", 0, 0);
    check("snz_limit_snoozing", 0, int'(snoozing_o[0]), 0);

    // Snooze and dismiss together: dismiss wins
    load_both(12, 0, 11, 59, 3);
    ticks(60);
    idle_cyc();
    lit_alarm("noon_ring", 1, 1);
    @(negedge clk); clr(); snooze = 1; dismiss = 1;
    idle_cyc();
    lit_alarm("sd_alarm", 0, 0);
    check("sd_snoozing", 0, int'(snoozing_o[0]), 0);

    // Time load aborts snoozing
    load_time(11, 59, 3);
    ticks(60);
    do_snooze();
    idle_cyc();
    check("abort_pre", 0, int'(snoozing_o[0]), 1);
    load_time(3, 0, 3);
    idle_cyc();
    check("abort_snoozing", 0, int'(snoozing_o[0]), 0);
    lit_alarm("abort_alarm", 0, 0);

    // Out-of-range loads leave the time alone
    load_time(24, 10, 2);
    idle_cyc();
    check("bad_hour", 0, int'(hour_o[0]), 3);
    load_time(5, 60, 2);
    idle_cyc();
    check("bad_min", 0, int'(minute_o[0]), 0);
    load_time(5, 5, 7);
    idle_cyc();
    check("bad_day", 0, int'(day_o[0]), 3);

    // Alarm set to the current time does not ring until the time comes round
    @(negedge clk); clr(); alarm_load = 1; load_hour = 5'd3; load_min = 6'd0;
    ticks(100);
    idle_cyc();
    lit_alarm("equal_noring", 0, 0);
    load_time(2, 59, 4);
    ticks(60);
    idle_cyc();
    lit_alarm("equal_later", 1, 1);
    do_dismiss();

    // Randomised traffic
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); clr();
      reset = ($urandom_range(0, 2999) == 0);
      sec_tick = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 299) == 0) begin
        time_load = 1;
        load_hour = 5'($urandom_range(0, 25));
        load_min  = 6'($urandom_range(0, 61));
        load_day  = 3'($urandom_range(0, 7));
      end else if ($urandom_range(0, 199) == 0) begin
        alarm_load = 1;
        load_hour = 5'((m_t[0] / 3600) % 24);
        load_min  = 6'((m_t[0] / 60) % 60 + int'($urandom_range(0, 2)));
      end
      snooze  = ($urandom_range(0, 39) == 0);
      dismiss = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 99) == 0) alarm_arm = ~alarm_arm;
    end
    reset = 0;
    idle_cyc();
    idle_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
